ecc_sed_enc_arbiter: RTL and testbench
======================================

# ecc_sed_enc_arbiter

Round-robin scheduler that shares one `ecc_sed_encoder` instance between `NUM_REQ` independent requesters. It owns the encoder's `data`/`data_valid` inputs and registers the returned codeword together with the winning requester's ID. Results go out on a single valid/ready stream. It sits between the producer ports of the write path and the memory-side codeword sink.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 12: data width; codeword width is `DATA_W+1`.
- `CNT_W`, 16: width of the accepted-transaction counter.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`  per-requester valid.
- `req_data`  in  `NUM_REQ*DATA_W`  requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  `NUM_REQ`  per-requester ready; at most one bit is high.
- `enc_data`  out  `DATA_W`  drives encoder `data`.
- `enc_data_valid`  out  1  drives encoder `data_valid`.
- `enc_codeword`  in  `DATA_W+1`  encoder `enc_codeword`.
- `enc_valid`  in  1  encoder `enc_valid`.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  downstream ready.
- `out_codeword`  out  `DATA_W+1`  registered codeword.
- `out_id`  out  `$clog2(NUM_REQ)`  index of the requester that produced `out_codeword`.
- `accept_cnt`  out  `CNT_W`  number of accepted requests, saturating.

## Operation
- Reset values: `out_valid`=0, `out_codeword`=0, `out_id`=0, `accept_cnt`=0, round-robin pointer `ptr`=0.
- Grant (combinational): search for a requester with `req_valid` set, starting at `ptr` and wrapping upward modulo `NUM_REQ`. The first hit is `gnt_idx`; `any_req` is high when any requester is valid.
- `slot_free` = `!out_valid || out_ready`.
- `req_ready[i]` = `any_req && slot_free && (i == gnt_idx)`. `req_ready` never depends on `req_valid[i]` of the same index beyond the search itself.
- `enc_data` = `req_data` slice of `gnt_idx`. When `any_req`=0, `enc_data` is 0.
- `enc_data_valid` = `any_req && slot_free`.
- Accept = `enc_data_valid && enc_valid`. On accept:
  - `out_codeword` <= `enc_codeword`
  - `out_id` <= `gnt_idx`
  - `out_valid` <= 1
  - `ptr` <= (`gnt_idx`+1) mod `NUM_REQ`
  - `accept_cnt` increments, saturating at all-ones.
- Without an accept, `out_valid` clears when `out_ready`=1 and otherwise holds. `ptr` holds.
- Simultaneous drain and accept (`out_valid`=1, `out_ready`=1, new accept): the register is overwritten with the new result and `out_valid` stays 1. There is no bubble.
- Backpressure (`out_valid`=1, `out_ready`=0): all `req_ready`=0, `enc_data_valid`=0, and `out_*` are stable.
- If `enc_valid`=0 while `enc_data_valid`=1, no accept occurs, `req_ready` is still asserted, and `ptr` is unchanged. Requesters must treat the handshake as void. Integration ties `enc_valid` to `enc_data_valid` through the encoder.
- Reset mid-transfer: the pending result is discarded, `out_valid`=0, and `ptr`=0 immediately (asynchronous).

## Timing
- Latency: request accepted in cycle N, result appears on `out_valid` in cycle N+1.
- Throughput: one result per cycle while `out_ready`=1.
- Fairness: with all requesters continuously valid, grants follow the sequence 0,1,…,`NUM_REQ`-1,0,…. Any valid requester is granted within `NUM_REQ` accepts.
- The encoder path is combinational within the cycle: `req_data` → `enc_data` → `enc_codeword` → result register.

## Structure
- Shared package `ecc_sed_pkg`:
  - `DATA_W`, `CW_W` = `DATA_W+1`
  - `NUM_REQ_MAX` = 8
  - typedef `sed_cw_t` (logic [`CW_W`-1:0])
  - function `rr_id_w(n)` = `$clog2(n)`
- One sub-module, `ecc_sed_rr_pick`: a combinational rotating priority picker. Inputs are `req` and `ptr`; outputs are `gnt_idx` and `any`.
- The encoder is instantiated by the parent, not inside this block.

## Test plan
- Reset: assert `rst` mid-stream with `out_valid`=1. Expect `out_valid`=0, `accept_cnt`=0, and the next grant going to requester 0 if valid.
- Single request: requester 2 presents 0x0A5 with `out_ready`=1. Expect `req_ready`=4'b0100 in the same cycle; next cycle `out_valid`=1, `out_id`=2, `out_codeword[11:0]`=0x0A5, and `out_codeword[12]` equal to the encoder parity.
- Round-robin: all four requesters are valid for 8 cycles with `out_ready`=1. Expect `out_id` sequence 0,1,2,3,0,1,2,3 and `accept_cnt`=8.
- Backpressure: hold `out_ready`=0 for 5 cycles with requests pending. Expect `req_ready`=0 and `out_codeword`/`out_id` stable. On release, the next requester in rotation is granted, and drain plus reload happen in the same cycle with no bubble.
- Sparse, wrapping: with `ptr`=3, only requester 1 is valid. Expect requester 1 to be granted and `ptr` to become 2.
- Counter saturation: with `CNT_W`=4, make 20 accepts. Expect `accept_cnt`=15, holding.

Source files
------------

// File: rtl/ecc_sed_pkg.sv
// Shared definitions for the single-error-detect (parity) encoder path.
package ecc_sed_pkg;

  localparam int unsigned DATA_W      = 12;
  localparam int unsigned CW_W        = DATA_W + 1;
  localparam int unsigned NUM_REQ_MAX = 8;

  typedef logic [CW_W-1:0] sed_cw_t;

  // Width of a requester index for n requesters.
  function automatic int unsigned rr_id_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/ecc_sed_rr_pick.sv
// Combinational rotating-priority picker: first set bit of req at or above ptr,
// wrapping modulo N.
module ecc_sed_rr_pick
  import ecc_sed_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = rr_id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  // Walk the requesters in rotation order starting at ptr; keep the first hit.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned idx;
      idx = (32'(ptr) + k) % N;
      if (!any && req[W'(idx)]) begin
        any     = 1'b1;
        gnt_idx = W'(idx);
      end
    end
  end

endmodule

// File: rtl/ecc_sed_enc_arbiter.sv
// Round-robin scheduler sharing one parity encoder between NUM_REQ requesters,
// with a single-entry result register on a valid/ready output stream.
module ecc_sed_enc_arbiter
  import ecc_sed_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned ID_W   = rr_id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         enc_data,
  output logic                      enc_data_valid,
  input  logic [DATA_W:0]           enc_codeword,
  input  logic                      enc_valid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W:0]           out_codeword,
  output logic [ID_W-1:0]           out_id,
  output logic [CNT_W-1:0]          accept_cnt
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [DATA_W:0]  out_cw_q, out_cw_d;
  logic [ID_W-1:0]  out_id_q, out_id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ID_W-1:0]  gnt_idx;
  logic             any_req;
  logic             slot_free;
  logic             accept;

  ecc_sed_rr_pick #(.N(NUM_REQ)) u_pick (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .any     (any_req)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign accept    = enc_data_valid && enc_valid;

  // Steer the granted requester to the encoder and raise its ready.
  always_comb begin
    enc_data_valid = any_req && slot_free;
    req_ready      = '0;
    enc_data       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        req_ready[i] = enc_data_valid;
        if (any_req) enc_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Result register, rotation pointer and saturating accept counter.
  // An accept while draining overwrites the register so out_valid never drops.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_cw_d    = out_cw_q;
    out_id_d    = out_id_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_cw_d    = enc_codeword;
      out_id_d    = gnt_idx;
      ptr_d       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_cw_q    <= '0;
      out_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_cw_q    <= out_cw_d;
      out_id_q    <= out_id_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_codeword = out_cw_q;
  assign out_id       = out_id_q;
  assign accept_cnt   = cnt_q;

endmodule

// File: tb/tb_ecc_sed_enc_arbiter.sv
// Self-checking bench for ecc_sed_enc_arbiter: randomized and directed stimulus
// against a behavioural model; a second instance with a 4-bit counter checks saturation.
module tb_ecc_sed_enc_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [47:0] req_data;
  logic        out_ready;
  logic        enc_ok;

  always #5 clk = ~clk;

  // Instance A: default 16-bit counter.
  logic [3:0]  rdy_a;
  logic [11:0] ed_a;
  logic        edv_a;
  logic [12:0] cwin_a;
  logic        ev_a;
  logic        ov_a;
  logic [12:0] ocw_a;
  logic [1:0]  oid_a;
  logic [15:0] cnt_a;

  // Instance B: 4-bit counter.
  logic [3:0]  rdy_b;
  logic [11:0] ed_b;
  logic        edv_b;
  logic [12:0] cwin_b;
  logic        ev_b;
  logic        ov_b;
  logic [12:0] ocw_b;
  logic [1:0]  oid_b;
  logic [3:0]  cnt_b;

  // Encoder stand-ins: even parity appended as the MSB.
  assign cwin_a = {^ed_a, ed_a};
  assign ev_a   = edv_a & enc_ok;
  assign cwin_b = {^ed_b, ed_b};
  assign ev_b   = edv_b & enc_ok;

  ecc_sed_enc_arbiter #(.NUM_REQ(4), .DATA_W(12), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_a), .enc_data(ed_a), .enc_data_valid(edv_a),
    .enc_codeword(cwin_a), .enc_valid(ev_a), .out_valid(ov_a),
    .out_ready(out_ready), .out_codeword(ocw_a), .out_id(oid_a),
    .accept_cnt(cnt_a)
  );

  ecc_sed_enc_arbiter #(.NUM_REQ(4), .DATA_W(12), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy_b), .enc_data(ed_b), .enc_data_valid(edv_b),
    .enc_codeword(cwin_b), .enc_valid(ev_b), .out_valid(ov_b),
    .out_ready(out_ready), .out_codeword(ocw_b), .out_id(oid_b),
    .accept_cnt(cnt_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  int          m_ptr, m_id, m_cnt;
  bit          m_ov;
  logic [12:0] m_cw;
  // Expected combinational outputs for the currently driven inputs.
  int          e_gnt;
  bit          e_any, e_edv;
  logic [3:0]  e_rdy;
  logic [11:0] e_ed;

  // Requester with the smallest cyclic distance from p, -1 if none.
  function automatic int pick_first(input logic [3:0] v, input int p);
    int best  = -1;
    int bestd = 99;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        int d = (i - p + 4) % 4;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  function automatic int min15(input int x);
    return (x > 15) ? 15 : x;
  endfunction

  task automatic drive(input logic [3:0] v, input logic [47:0] d, input logic r, input logic ok);
    req_valid = v;
    req_data  = d;
    out_ready = r;
    enc_ok    = ok;
    #1;
    e_gnt = pick_first(v, m_ptr);
    e_any = (v != 4'b0);
    e_edv = e_any && (!m_ov || r);
    e_rdy = e_edv ? (4'b0001 << e_gnt) : 4'b0000;
    e_ed  = e_any ? d[e_gnt*12 +: 12] : 12'h000;
  endtask

  task automatic tick();
    @(posedge clk);
    if (e_edv && enc_ok) begin
      m_cw  = {^e_ed, e_ed};
      m_id  = e_gnt;
      m_ov  = 1'b1;
      m_ptr = (e_gnt + 1) % 4;
      m_cnt = m_cnt + 1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_cnt = 0; m_ov = 1'b0; m_cw = '0;
  endtask

  task automatic do_reset();
    drive(4'b0000, '0, 1'b1, 1'b1);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [47:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    logic [47:0] d;
    rst = 1'b1;
    model_reset();
    drive(4'b0000, '0, 1'b1, 1'b1);
    n_cmp++;
    if ({ov_a, oid_a, ocw_a, cnt_a} !== {1'b0, 2'd0, 13'd0, 16'd0}) begin
      n_err++;
      $display("FAIL reset_values: got ov=%0b id=%0d cw=%h cnt=%0d, want 0/0/0/0", ov_a, oid_a, ocw_a, cnt_a);
    end
    @(negedge clk);
    rst = 1'b0;
    // Two accepts with backpressure so a result is pending, then async reset.
    drive(4'hF, rnd_data(), 1'b1, 1'b1);
    tick();
    drive(4'hF, rnd_data(), 1'b1, 1'b1);
    tick();
    drive(4'hF, rnd_data(), 1'b0, 1'b1);
    n_cmp++;
    if (ov_a !== 1'b1 || m_ov !== 1'b1) begin
      n_err++;
      $display("FAIL reset_prefill: got ov=%0b, want 1", ov_a);
    end
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_cmp++;
    if ({ov_a, cnt_a, cnt_b} !== {1'b0, 16'd0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_async: got ov=%0b cnt=%0d cntb=%0d, want 0/0/0", ov_a, cnt_a, cnt_b);
    end
    @(negedge clk);
    rst = 1'b0;
    d = rnd_data();
    drive(4'hF, d, 1'b1, 1'b1);
    n_cmp++;
    if (rdy_a !== 4'b0001 || rdy_a !== e_rdy) begin
      n_err++;
      $display("FAIL reset_ptr: got req_ready=%b, want 0001", rdy_a);
    end
    tick();
  endtask

  task automatic test_single();
    logic [47:0] d;
    do_reset();
    d = rnd_data();
    d[24 +: 12] = 12'h0A5;
    drive(4'b0100, d, 1'b1, 1'b1);
    n_cmp++;
    if (rdy_a !== 4'b0100 || ed_a !== 12'h0A5 || edv_a !== 1'b1) begin
      n_err++;
      $display("FAIL single_grant: got req_ready=%b enc_data=%h edv=%0b, want 0100/0a5/1", rdy_a, ed_a, edv_a);
    end
    tick();
    n_cmp++;
    if (ov_a !== 1'b1 || oid_a !== 2'd2 || ocw_a[11:0] !== 12'h0A5 || ocw_a[12] !== 1'b0) begin
      n_err++;
      $display("FAIL single_result: got ov=%0b id=%0d cw=%h, want 1/2/00a5", ov_a, oid_a, ocw_a);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(4'hF, rnd_data(), 1'b1, 1'b1);
      n_cmp++;
      if (rdy_a !== (4'b0001 << (k % 4))) begin
        n_err++;
        $display("FAIL rr_grant[%0d]: got req_ready=%b, want %b", k, rdy_a, 4'b0001 << (k % 4));
      end
      tick();
      n_cmp++;
      if (oid_a !== 2'(k % 4) || ocw_a !== m_cw || ov_a !== 1'b1) begin
        n_err++;
        $display("FAIL rr_result[%0d]: got id=%0d cw=%h ov=%0b, want %0d/%h/1", k, oid_a, ocw_a, ov_a, k % 4, m_cw);
      end
    end
    n_cmp++;
    if (cnt_a !== 16'd8) begin
      n_err++;
      $display("FAIL rr_count: got %0d, want 8", cnt_a);
    end
  endtask

  task automatic test_backpressure();
    logic [12:0] s_cw;
    logic [1:0]  s_id;
    s_cw = ocw_a;
    s_id = oid_a;
    for (int k = 0; k < 5; k++) begin
      drive(4'hF, rnd_data(), 1'b0, 1'b1);
      n_cmp++;
      if (rdy_a !== 4'b0000 || edv_a !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready[%0d]: got req_ready=%b edv=%0b, want 0000/0", k, rdy_a, edv_a);
      end
      tick();
      n_cmp++;
      if (ocw_a !== s_cw || oid_a !== s_id || ov_a !== 1'b1) begin
        n_err++;
        $display("FAIL bp_stable[%0d]: got cw=%h id=%0d ov=%0b, want %h/%0d/1", k, ocw_a, oid_a, ov_a, s_cw, s_id);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive(4'hF, rnd_data(), 1'b1, 1'b1);
      n_cmp++;
      if (rdy_a !== (4'b0001 << k) || rdy_a !== e_rdy) begin
        n_err++;
        $display("FAIL bp_release[%0d]: got req_ready=%b, want %b", k, rdy_a, 4'b0001 << k);
      end
      tick();
      n_cmp++;
      if (ov_a !== 1'b1 || oid_a !== 2'(k) || ocw_a !== m_cw) begin
        n_err++;
        $display("FAIL bp_nobubble[%0d]: got ov=%0b id=%0d cw=%h, want 1/%0d/%h", k, ov_a, oid_a, ocw_a, k, m_cw);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    do_reset();
    drive(4'b0100, rnd_data(), 1'b1, 1'b1);
    tick();
    drive(4'b0010, rnd_data(), 1'b1, 1'b1);
    n_cmp++;
    if (rdy_a !== 4'b0010) begin
      n_err++;
      $display("FAIL wrap_grant: got req_ready=%b, want 0010", rdy_a);
    end
    tick();
    n_cmp++;
    if (oid_a !== 2'd1 || ocw_a !== m_cw) begin
      n_err++;
      $display("FAIL wrap_result: got id=%0d cw=%h, want 1/%h", oid_a, ocw_a, m_cw);
    end
    drive(4'hF, rnd_data(), 1'b1, 1'b1);
    n_cmp++;
    if (rdy_a !== 4'b0100) begin
      n_err++;
      $display("FAIL wrap_ptr: got req_ready=%b, want 0100", rdy_a);
    end
    tick();
  endtask

  task automatic test_void_handshake();
    do_reset();
    drive(4'hF, rnd_data(), 1'b1, 1'b0);
    n_cmp++;
    if (rdy_a !== 4'b0001 || edv_a !== 1'b1) begin
      n_err++;
      $display("FAIL void_ready: got req_ready=%b edv=%0b, want 0001/1", rdy_a, edv_a);
    end
    tick();
    n_cmp++;
    if (ov_a !== 1'b0 || cnt_a !== 16'd0) begin
      n_err++;
      $display("FAIL void_noaccept: got ov=%0b cnt=%0d, want 0/0", ov_a, cnt_a);
    end
    drive(4'hF, rnd_data(), 1'b1, 1'b1);
    n_cmp++;
    if (rdy_a !== 4'b0001) begin
      n_err++;
      $display("FAIL void_ptr: got req_ready=%b, want 0001", rdy_a);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(4'hF, rnd_data(), 1'b1, 1'b1);
      tick();
    end
    n_cmp++;
    if (cnt_b !== 4'd15 || cnt_a !== 16'd20) begin
      n_err++;
      $display("FAIL sat_count: got cnt4=%0d cnt16=%0d, want 15/20", cnt_b, cnt_a);
    end
    drive(4'hF, rnd_data(), 1'b1, 1'b1);
    tick();
    n_cmp++;
    if (cnt_b !== 4'd15) begin
      n_err++;
      $display("FAIL sat_hold: got cnt4=%0d, want 15", cnt_b);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive(4'($urandom_range(0, 15)), rnd_data(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) != 0));
      n_cmp++;
      if ({rdy_a, edv_a, ed_a} !== {e_rdy, e_edv, e_ed} || !$onehot0(rdy_a)) begin
        n_err++;
        $display("FAIL rand_comb[%0d]: got rdy=%b edv=%0b ed=%h, want %b/%0b/%h", k, rdy_a, edv_a, ed_a, e_rdy, e_edv, e_ed);
      end
      tick();
      n_cmp++;
      if ({ov_a, oid_a, ocw_a} !== {m_ov, 2'(m_id), m_cw} || cnt_a !== 16'(m_cnt)
          || cnt_b !== 4'(min15(m_cnt)) || ov_b !== m_ov) begin
        n_err++;
        $display("FAIL rand_reg[%0d]: got ov=%0b id=%0d cw=%h cnt=%0d cnt4=%0d, want %0b/%0d/%h/%0d/%0d",
                 k, ov_a, oid_a, ocw_a, cnt_a, cnt_b, m_ov, m_id, m_cw, m_cnt, min15(m_cnt));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sparse_wrap();
    test_void_handshake();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
